uart_receiver: RTL
==================

# uart_receiver

Serial-to-parallel UART receiver for the CPU's RX path: consumes the IOB-registered `FPGA_SERIAL_RX` line and delivers framed 8N1 bytes through a ready/valid handshake to the CPU's memory-mapped UART. It is the receive-side counterpart of the CPU's serial transmitter. Line sampling is at mid-bit. Framing errors and overruns are flagged as single-cycle pulses.

## Interface

- `CLOCK_FREQ`, default 125_000_000, clock frequency in Hz (CPU_CLOCK_FREQ at the top level).
- `BAUD_RATE`, default 115_200, line rate in baud.
- `clk`  input  1  CPU clock; all logic is on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `serial_in`  input  1  RX line, idle high; asynchronous to `clk`.
- `data_out`  output  8  received byte, valid while `data_out_valid`=1.
- `data_out_valid`  output  1  holding register full.
- `data_out_ready`  input  1  consumer accepts the byte when `data_out_valid`=1.
- `framing_error`  output  1  one-cycle pulse: stop bit sampled 0.
- `overrun`  output  1  one-cycle pulse: new byte dropped because the holding register was full.

## Operation

- Derived constants:
  - `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE`, using integer truncation.
  - `SAMPLE_TIME = SYMBOL_EDGE_TIME / 2`.
  - The cycle counter is `$clog2(SYMBOL_EDGE_TIME)` bits wide.
- `serial_in` passes through a 2-flop synchronizer, which resets to 1. A 1-flop delayed copy (`rx_prev`) provides edge detection.
- FSM states: `IDLE`, `START`, `DATA`, `STOP`.
  - `IDLE`: when `rx_prev`=1 and `rx`=0 (falling edge), clear the counter and go to `START`. A held-low line (break) never retriggers.
  - `START`: at count `SAMPLE_TIME-1`, sample `rx`. If `rx`=1 it was a glitch; go back to `IDLE` with no flags. If `rx`=0, clear the counter, set bit index to 0 and go to `DATA`.
  - `DATA`: at count `SYMBOL_EDGE_TIME-1`, shift `rx` into bit `[index]` (LSB first) and clear the counter. After bit 7, go to `STOP`.
  - `STOP`: at count `SYMBOL_EDGE_TIME-1`, sample `rx`, then go to `IDLE`.
    - `rx`=1, holding register empty or being drained this cycle: load the byte and set `data_out_valid`.
    - `rx`=1, holding register full and not draining: pulse `overrun`. The old byte is retained and the new one is discarded.
    - `rx`=0: pulse `framing_error`. The byte is discarded and the holding register is untouched.
- Handshake:
  - `data_out_valid && data_out_ready` clears valid on the next edge.
  - `data_out` is stable while valid is high.
  - If accept and a new load happen in the same cycle, the new byte is loaded, valid stays 1 and there is no overrun.

## Timing

- Reset values:
  - Outputs: `data_out`=8'h00, `data_out_valid`=0, `framing_error`=0, `overrun`=0.
  - Internal: FSM=`IDLE`, synchronizer and `rx_prev` flops=1.
- Latency: `data_out_valid` rises 1 cycle after the stop-bit sample. The stop-bit sample occurs about 2 + 9.5·`SYMBOL_EDGE_TIME` cycles after the pin's falling edge.
- Throughput: back-to-back frames with zero idle time are received, because `IDLE` is re-entered half a bit before the next start edge.
- `framing_error` and `overrun` are high for exactly 1 cycle. They are never asserted at the same time.
- Reset mid-frame aborts immediately with no flags and no partial byte. After release, the receiver waits for a fresh falling edge.

## Structure

- Shared package (`uart_pkg`):
  - FSM state encodings as localparams.
  - Helper functions for `SYMBOL_EDGE_TIME`/`SAMPLE_TIME`, also used by the transmitter.
- Sub-module: instantiate the existing `synchronizer` (`WIDTH`=1) for `serial_in`. Its flops must reset to 1; add a reset-value parameter to `synchronizer` if it does not already have one.
- Everything else (counter, shift register, holding register, FSM) is inline: one module, about 150 lines.

## Test plan

Bench parameters: `CLOCK_FREQ`=1_000_000, `BAUD_RATE`=100_000, giving 10 cycles/bit.

- Clean byte: send 8'hA5 (8N1), `data_out_ready`=1 → `data_out_valid` pulses 1 cycle with `data_out`=8'hA5; no flags.
- Glitch rejection: drive `serial_in` low for 3 cycles, then high → no valid, no flags, FSM back in `IDLE`.
- Framing error: send 8'h3C with stop bit 0 → `framing_error`=1 for 1 cycle; `data_out_valid` stays 0. Line then held low 50 cycles → no retrigger.
- Overrun and back-to-back: send 8'h11 then 8'h22 back-to-back, `data_out_ready`=0 → `data_out`=8'h11 held; `overrun` pulses at the second stop bit. Assert ready → valid drops.
- Simultaneous accept: hold valid with 8'h11. Assert ready in exactly the cycle 8'h22 completes → `data_out`=8'h22, valid stays 1, no `overrun`.
- Reset mid-frame: assert `rst` during data bit 4 of 8'hFF, release, then send 8'h5A → only 8'h5A is delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants: FSM encodings and baud timing helpers
package uart_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

   function automatic int sample_time(input int clock_freq, input int baud_rate);
      return symbol_edge_time(clock_freq, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/synchronizer.sv
// rtl/synchronizer.sv - two-flop synchronizer with a configurable reset value
module synchronizer #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_signal,
   output logic [WIDTH-1:0] sync_signal
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta        <= RESET_VALUE;
         sync_signal <= RESET_VALUE;
      end else begin
         meta        <= async_signal;
         sync_signal <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver, mid-bit sampling, ready/valid byte output
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   output logic       framing_error,
   output logic       overrun
);

   localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
   localparam int SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
   localparam int CNT_W            = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
   localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

   logic             rx;
   logic             rx_prev;
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;

   synchronizer #(
      .WIDTH       (1),
      .RESET_VALUE (1'b1)
   ) rx_sync (
      .clk          (clk),
      .rst          (rst),
      .async_signal (serial_in),
      .sync_signal  (rx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         bit_idx        <= '0;
         shift_reg      <= '0;
         rx_prev        <= 1'b1;
         data_out       <= 8'h00;
         data_out_valid <= 1'b0;
         framing_error  <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         rx_prev       <= rx;
         framing_error <= 1'b0;
         overrun       <= 1'b0;

         if (data_out_valid && data_out_ready)
            data_out_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               cnt <= '0;
               // Edge-triggered so a held-low line (break) never restarts a frame.
               if (rx_prev && !rx)
                  state <= ST_START;
            end
            ST_START: begin
               cnt <= cnt + 1'b1;
               if (cnt == SAMPLE_LAST) begin
                  if (rx) begin
                     state <= ST_IDLE;
                  end else begin
                     cnt     <= '0;
                     bit_idx <= '0;
                     state   <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               cnt <= cnt + 1'b1;
               if (cnt == SYMBOL_LAST) begin
                  shift_reg[bit_idx] <= rx;
                  cnt                <= '0;
                  if (bit_idx == 3'd7)
                     state <= ST_STOP;
                  else
                     bit_idx <= bit_idx + 1'b1;
               end
            end
            ST_STOP: begin
               cnt <= cnt + 1'b1;
               // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
               if (cnt == SYMBOL_LAST) begin
                  state <= ST_IDLE;
                  if (!rx) begin
                     framing_error <= 1'b1;
                  end else if (!data_out_valid || data_out_ready) begin
                     data_out       <= shift_reg;
                     data_out_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
